// File: rtl/serial_adder.sv
// Bit-serial adder: two half adders and an OR form the bit slice,
// a carry flop links slices across cycles, LSB first.
module half_adder (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);
    assign sum   = x ^ y;
    assign carry = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] ra, rb, rs, rs_next;
    logic [CW-1:0]    cnt;
    logic             carry, carry_next;
    logic             p, g0, g1, sbit;

    half_adder ha0 (.x(ra[0]), .y(rb[0]), .sum(p),    .carry(g0));
    half_adder ha1 (.x(p),     .y(carry), .sum(sbit), .carry(g1));

    assign carry_next = g0 | g1;

    // Shift the new sum bit in at the top; works for WIDTH=1 too
    always_comb begin
        rs_next = rs >> 1;
        rs_next[WIDTH-1] = sbit;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= cin;
                        rs    <= '0;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    carry <= carry_next;
                    rs    <= rs_next;
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s    <= rs_next;
                        cout <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances, scoreboard
// queues of expected {cout,s}, immediate-assertion checks.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, s8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, s1;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at edge+1; leaves the bench one cycle after done, in IDLE
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [8:0] held);
        logic [8:0] exp;
        int lat;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        cin8 = c;
        q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
        tick();
        start8 = 1'b0;
        a8 = 8'hFF;
        b8 = 8'hFF;
        cin8 = 1'b1;
        chk("busy8_after_start", {31'd0, busy8}, 1);
        chk("s8_held_during_add", {23'd0, cout8, s8}, {23'd0, held});
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            chk("done8_early", {31'd0, done8}, 0);
            tick();
            lat++;
        end
        chk("lat8", lat, 8);
        if (q8.size() == 0) begin
            chk("q8_empty", 1, 0);
        end else begin
            exp = q8.pop_front();
            chk("sum8", {23'd0, cout8, s8}, {23'd0, exp});
        end
        tick();
        chk("done8_one_cycle", {31'd0, done8}, 0);
        chk("busy8_idle", {31'd0, busy8}, 0);
    endtask

    task automatic op1(input logic a, input logic b, input logic c);
        logic [1:0] exp;
        int lat;
        start1 = 1'b1;
        a1 = a;
        b1 = b;
        cin1 = c;
        q1.push_back({1'b0, a} + {1'b0, b} + {1'b0, c});
        tick();
        start1 = 1'b0;
        a1 = ~a;
        b1 = ~b;
        cin1 = ~c;
        chk("busy1_after_start", {31'd0, busy1}, 1);
        lat = 0;
        while (done1 !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("lat1", lat, 1);
        if (q1.size() == 0) begin
            chk("q1_empty", 1, 0);
        end else begin
            exp = q1.pop_front();
            chk("sum1", {30'd0, cout1, s1}, {30'd0, exp});
        end
        tick();
        chk("done1_one_cycle", {31'd0, done1}, 0);
    endtask

    initial begin
        logic [8:0] exp;
        int ndone;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #2;
        chk("rst_busy8", {31'd0, busy8}, 0);
        chk("rst_done8", {31'd0, done8}, 0);
        chk("rst_s8", {23'd0, cout8, s8}, 0);
        chk("rst_s1", {29'd0, busy1, cout1, s1}, 0);
        #21;
        rst_n = 1'b1;
        tick();

        op8(8'h00, 8'h00, 1'b0, 9'h000);
        op8(8'hFF, 8'h01, 1'b0, 9'h000);
        op8(8'h3C, 8'h42, 1'b1, 9'h100);
        op8(8'h5A, 8'hA5, 1'b1, 9'h07F);
        op8(8'h01, 8'h02, 1'b0, 9'h100);

        // start held high: accepted every WIDTH+2 cycles
        start8 = 1'b1;
        a8 = 8'h10;
        b8 = 8'h20;
        cin8 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 0) q8.push_back(9'h030);
            tick();
            if (i == 29) start8 = 1'b0;
            chk("held_done", {31'd0, done8}, (i % 10 == 8) ? 1 : 0);
            chk("held_busy", {31'd0, busy8}, (i % 10 == 9) ? 0 : 1);
            if (done8 === 1'b1) begin
                ndone++;
                if (q8.size() == 0) begin
                    chk("q8_empty_held", 1, 0);
                end else begin
                    exp = q8.pop_front();
                    chk("held_sum", {23'd0, cout8, s8}, {23'd0, exp});
                end
            end
        end
        chk("held_ndone", ndone, 3);

        // abort mid-ADD with an asynchronous reset
        start8 = 1'b1;
        a8 = 8'h80;
        b8 = 8'h80;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        chk("pre_abort_busy", {31'd0, busy8}, 1);
        chk("pre_abort_s", {23'd0, cout8, s8}, 9'h030);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy8}, 0);
        chk("abort_done", {31'd0, done8}, 0);
        chk("abort_s", {23'd0, cout8, s8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_done_after_abort", {31'd0, done8}, 0);
        end
        op8(8'h80, 8'h80, 1'b0, 9'h000);

        for (int i = 0; i < 8; i++) begin
            op1(i[2], i[1], i[0]);
        end

        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that consumes the half-adder cell: two half adders plus an OR form a full-adder bit slice, and a carry flip-flop links the slices across cycles.
- Operands and carry-in are captured on a start handshake and added LSB first, one bit per clock.
- The sum and carry-out are presented with a one-cycle done pulse.
- Used wherever area matters more than latency. It is the sequential stage built directly on the half-adder primitive.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 1..32)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; sampled on accepted start
b  input  WIDTH  operand B; sampled on accepted start
cin  input  1  carry-in; sampled on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; s and cout are valid and stable
s  output  WIDTH  sum register; holds its value until the next completion
cout  output  1  carry-out register; holds its value until the next completion

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asserted): state=IDLE, busy=0, done=0, s=0, cout=0. Internal shift registers, carry flop and counter are cleared.
- Reset release: start is accepted on the first rising edge with rst_n high.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at an edge: load ra<=a, rb<=b, carry<=cin, rs<=0, cnt<=0; go to ADD.
  - start=0: stay in IDLE.
- ADD, at each edge:
  - sbit = ra[0]^rb[0]^carry.
  - carry <= (ra[0]&rb[0]) | (carry&(ra[0]^rb[0])).
  - rs <= {sbit, rs[WIDTH-1:1]}.
  - ra, rb shift right one place (MSB filled with 0).
  - cnt <= cnt+1.
- ADD exit: at the edge where cnt==WIDTH-1, the final bit is processed. At that same edge: s <= completed sum (final sbit in the MSB), cout <= final carry, state <= DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k. done is high between edge k+WIDTH and edge k+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles (IDLE→ADD→DONE→IDLE) with start held high.
- start while busy (ADD or DONE) is ignored, with no queuing. A start held high continuously is accepted on the first edge seen in IDLE.
- a, b, cin are don't-care outside the accepting edge. Changes during ADD must not affect the result.
- Arithmetic: {cout,s} = a + b + cin, modulo 2^(WIDTH+1). Overflow is reported only through cout, with no other flag.
- s and cout change only at the edge entering DONE. They are stable through DONE and IDLE and during the next ADD, until the next completion.
- Reset mid-operation: immediate abort with the reset values above. No done is produced for the aborted operation.
- WIDTH=1: ADD lasts one cycle; done is high between edge k+1 and edge k+2.
- Outputs are registered or decoded directly from state only (busy, done). There is no combinational path from inputs to outputs.

Test Plan:
1. WIDTH=8. a=0x00, b=0x00, cin=0, start pulse at edge k -> busy=1 from edge k; done=1 only between edges k+8 and k+9; s=0x00, cout=0.
2. a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1 (wrap-around). Then a=0x3C, b=0x42, cin=1 -> s=0x7F, cout=0.
3. a=0x5A, b=0xA5, cin=1; drive a=0xFF, b=0xFF during ADD -> s=0x00, cout=1 (captured operands used). s holds 0x00 until the next done.
4. start held high for 30 cycles with a=0x10, b=0x20, cin=0 -> starts accepted every 10 cycles; exactly 3 done pulses, each with s=0x30, cout=0; busy low for exactly one cycle between operations.
5. Reset: start a=0x80, b=0x80; assert rst_n=0 asynchronously mid-cycle after the 4th ADD edge -> busy, done, s, cout go to 0 immediately, with no done pulse. Then release, start a=0x80, b=0x80, cin=0 -> s=0x00, cout=1.
6. WIDTH=1, all 8 (a,b,cin) combinations -> {cout,s} equals a+b+cin; done is high between edges k+1 and k+2 each time.
